// File: rtl/sqwave_gen_module_if.sv
// Control/status bundle between a sequencer and the square-wave/burst generator.
// The sequencer owns the request and configuration lines; the generator owns
// the waveform, status and observation lines.
interface sqwave_gen_module_if #(
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned BURST_W = 8
);

  // Requests and run-time configuration
  logic               start;
  logic               stop;
  logic               mode;
  logic [CNT_W-1:0]   high_len;
  logic [CNT_W-1:0]   low_len;
  logic [BURST_W-1:0] burst_num;

  // Waveform, status and observation
  logic               q;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   sq_cnt;
  logic [1:0]         sq_st;

  modport master (
    output start, stop, mode, high_len, low_len, burst_num,
    input  q, busy, done, sq_cnt, sq_st
  );

  modport slave (
    input  start, stop, mode, high_len, low_len, burst_num,
    output q, busy, done, sq_cnt, sq_st
  );

endinterface

// File: rtl/sqwave_gen_module.sv
// Square-wave / burst generator.
// Produces a registered waveform with programmable high and low phase lengths,
// either continuously or for a fixed number of periods. Configuration is
// captured on an accepted start and held until the next one; stop aborts from
// any state. Every output comes straight from a flop.
module sqwave_gen_module #(
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned BURST_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  sqwave_gen_module_if.slave  bus
);

  // State index is exported, so the encoding is fixed.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2,
    StDone = 2'd3
  } state_e;

  state_e             state_q;
  logic               q_q;
  logic               busy_q;
  logic               done_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BURST_W-1:0] per_q;

  // Configuration captured at start
  logic [CNT_W-1:0]   high_q;
  logic [CNT_W-1:0]   low_q;
  logic [BURST_W-1:0] burst_q;
  logic               mode_q;

  logic [CNT_W-1:0]   high_clamp;
  logic [CNT_W-1:0]   low_clamp;
  logic [BURST_W-1:0] burst_clamp;
  logic               high_last;
  logic               low_last;
  logic [BURST_W-1:0] per_inc;
  logic               burst_end;
  logic               accept;

  // A zero length or count would never terminate a phase, so it is stored as 1.
  assign high_clamp  = (bus.high_len  == '0) ? CNT_W'(1)   : bus.high_len;
  assign low_clamp   = (bus.low_len   == '0) ? CNT_W'(1)   : bus.low_len;
  assign burst_clamp = (bus.burst_num == '0) ? BURST_W'(1) : bus.burst_num;

  assign high_last = (cnt_q == high_q - CNT_W'(1));
  assign low_last  = (cnt_q == low_q - CNT_W'(1));

  // Period counter saturates so a long continuous run never wraps.
  assign per_inc   = (per_q == '1) ? per_q : per_q + BURST_W'(1);
  assign burst_end = mode_q && (per_inc == burst_q);

  // Stop has priority over a simultaneous start.
  assign accept = bus.start && !bus.stop;

  // Phase sequencing with registered waveform and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      q_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      per_q   <= '0;
      high_q  <= '0;
      low_q   <= '0;
      burst_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          q_q   <= 1'b0;
          cnt_q <= '0;
          if (accept) begin
            high_q  <= high_clamp;
            low_q   <= low_clamp;
            burst_q <= burst_clamp;
            mode_q  <= bus.mode;
            per_q   <= '0;
            state_q <= StHigh;
            q_q     <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        StHigh: begin
          if (bus.stop) begin
            state_q <= StIdle;
            q_q     <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (high_last) begin
            state_q <= StLow;
            q_q     <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        StLow: begin
          if (bus.stop) begin
            state_q <= StIdle;
            q_q     <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (low_last) begin
            cnt_q <= '0;
            per_q <= per_inc;
            if (burst_end) begin
              state_q <= StDone;
              q_q     <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StHigh;
              q_q     <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        StDone: begin
          // Single-cycle completion marker; stop here leads to the same place.
          state_q <= StIdle;
          q_q     <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.q      = q_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.sq_cnt = cnt_q;
  assign bus.sq_st  = state_q;

  // Structural invariants of the registered outputs.
  a_busy_state: assert property (@(posedge clk) disable iff (!rst_n)
    busy_q == (state_q != StIdle));
  a_q_state: assert property (@(posedge clk) disable iff (!rst_n)
    q_q == (state_q == StHigh));
  a_done_state: assert property (@(posedge clk) disable iff (!rst_n)
    done_q == (state_q == StDone));
  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    done_q |=> !done_q);
  a_high_cnt: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StHigh) |-> (cnt_q < high_q));
  a_low_cnt: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StLow) |-> (cnt_q < low_q));

endmodule

// File: tb/tb_sqwave_gen_module.sv
// Bench for the square-wave/burst generator. Expected outputs come from a
// closed-form model: the position inside a run is reduced modulo the period
// to get the phase, with burst end and stop handled as cut-off times.
module tb_sqwave_gen_module;

  localparam int CNT_W   = 5;
  localparam int BURST_W = 8;

  logic clk;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;
  bit q_hist [0:2047];

  sqwave_gen_module_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

  sqwave_gen_module #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Expected outputs t cycles after the start was sampled (t = 1 is the first
  // HIGH cycle). stop_k > 0: stop was driven in cycle stop_k.
  function automatic void exp_at(input int t, input int h, input int l, input int n,
                                 input int md, input int stop_k,
                                 output int eq, output int eb, output int ed,
                                 output int ec, output int es);
    int hc;
    int lc;
    int nc;
    int p;
    int ph;
    hc = (h == 0) ? 1 : h;
    lc = (l == 0) ? 1 : l;
    nc = (n == 0) ? 1 : n;
    p  = hc + lc;
    eq = 0; eb = 0; ed = 0; ec = 0; es = 0;
    if (stop_k > 0 && t > stop_k) return;
    if (md != 0 && t > nc * p) begin
      if (t == nc * p + 1) begin
        eb = 1; ed = 1; es = 3;
      end
      return;
    end
    ph = (t - 1) % p;
    eb = 1;
    if (ph < hc) begin
      eq = 1; ec = ph; es = 1;
    end else begin
      ec = ph - hc; es = 2;
    end
  endfunction

  task automatic scramble_cfg();
    bus.high_len  = CNT_W'($urandom);
    bus.low_len   = CNT_W'($urandom);
    bus.burst_num = BURST_W'($urandom);
    bus.mode      = ($urandom_range(0, 1) == 1);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " q"},      int'(bus.q),      0);
    check_eq({tag, " busy"},   int'(bus.busy),   0);
    check_eq({tag, " done"},   int'(bus.done),   0);
    check_eq({tag, " sq_cnt"}, int'(bus.sq_cnt), 0);
    check_eq({tag, " sq_st"},  int'(bus.sq_st),  0);
  endtask

  // Called at a falling edge with the DUT idle. Drives start with the given
  // config, then samples len cycles. stop / extra start are driven in cycles
  // stop_k / xs_k (0 = never); config inputs are scrambled after the latch.
  task automatic run_wave(input int h, input int l, input int n, input int md,
                          input int stop_k, input int xs_k, input int len);
    int eq, eb, ed, ec, es;
    bus.high_len  = CNT_W'(h);
    bus.low_len   = CNT_W'(l);
    bus.burst_num = BURST_W'(n);
    bus.mode      = (md != 0);
    bus.start     = 1'b1;
    bus.stop      = 1'b0;
    for (int t = 1; t <= len; t++) begin
      @(negedge clk);
      exp_at(t, h, l, n, md, stop_k, eq, eb, ed, ec, es);
      if (t < 2048) q_hist[t] = bus.q;
      check_eq($sformatf("q h%0d l%0d n%0d m%0d t%0d", h, l, n, md, t),
               int'(bus.q), eq);
      check_eq($sformatf("busy t%0d", t), int'(bus.busy), eb);
      check_eq($sformatf("done t%0d", t), int'(bus.done), ed);
      check_eq($sformatf("sq_cnt t%0d", t), int'(bus.sq_cnt), ec);
      check_eq($sformatf("sq_st t%0d", t), int'(bus.sq_st), es);
      bus.start = (t == xs_k);
      bus.stop  = (t == stop_k);
      scramble_cfg();
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  initial begin
    bit [9:0] burst_q_exp;
    int h, l, n, md, p, stop_k, xs_k, len, last_busy;

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.mode      = 1'b0;
    bus.high_len  = '0;
    bus.low_len   = '0;
    bus.burst_num = '0;

    // Long reset, then idle with no start
    repeat (100) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_idle("post-reset idle");
    end

    // Directed burst H=3 L=2 N=2
    run_wave(3, 2, 2, 1, 0, 0, 13);
    burst_q_exp = 10'b11100_11100;
    for (int t = 1; t <= 10; t++)
      check_eq($sformatf("burst q pattern t%0d", t), int'(q_hist[t]),
               int'(burst_q_exp[10 - t]));

    // Continuous minimum H=1 L=1, 1000 cycles, then stop
    run_wave(1, 1, 0, 0, 1000, 0, 1002);

    // Zero clamp in burst mode
    run_wave(0, 0, 0, 1, 0, 0, 5);

    // Start again during HIGH is ignored
    run_wave(4, 3, 2, 1, 0, 2, 17);

    // Stop at sq_cnt=1 of HIGH with H=5
    run_wave(5, 3, 2, 1, 2, 0, 6);

    // Start and stop together in IDLE
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    bus.high_len = CNT_W'(2);
    bus.low_len  = CNT_W'(2);
    bus.burst_num = BURST_W'(1);
    bus.mode  = 1'b1;
    @(negedge clk);
    check_idle("start+stop");
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    @(negedge clk);
    check_idle("start+stop after");

    // Asynchronous reset while in LOW (t=6 with H=4 is the 2nd LOW cycle)
    run_wave(4, 4, 3, 1, 0, 0, 6);
    #1 rst_n = 1'b0;
    #1 check_idle("async reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_wave(2, 3, 2, 1, 0, 0, 13);

    // Randomised runs
    for (int i = 0; i < 40; i++) begin
      h  = $urandom_range(0, 6);
      l  = $urandom_range(0, 6);
      n  = $urandom_range(0, 4);
      md = $urandom_range(0, 1);
      p  = ((h == 0) ? 1 : h) + ((l == 0) ? 1 : l);
      stop_k = 0;
      xs_k   = 0;
      if (md != 0) begin
        last_busy = ((n == 0) ? 1 : n) * p + 1;
        if ($urandom_range(0, 2) == 0) stop_k = $urandom_range(1, last_busy);
        len = (stop_k != 0) ? stop_k + 2 : last_busy + 2;
        if ($urandom_range(0, 1) == 1)
          xs_k = $urandom_range(1, (stop_k != 0) ? stop_k : last_busy);
      end else begin
        stop_k = $urandom_range(1, 40);
        len    = stop_k + 2;
        if ($urandom_range(0, 1) == 1) xs_k = $urandom_range(1, stop_k);
      end
      run_wave(h, l, n, md, stop_k, xs_k, len);
      @(negedge clk);
      check_idle("random gap");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
